// File: rtl/jtag_access_sequencer.sv
// rtl/jtag_access_sequencer.sv - virtual-JTAG DR sequencer bridging to the debug register bank bus
//
// Purpose: decodes the instruction register into read/write addresses, runs
// Capture-DR / Shift-DR / Update-DR on the main clock and converts them into
// single-outstanding read/write handshakes on the register-bank bus.
//
// Ports:
//   iMAIN_CLK, iRESET            clock, synchronous active-high reset
//   iIR                          {wr_en, wr_addr, rd_addr}
//   iTCK, iTDI, iSTATE_*         synchronized JTAG signals
//   oTDO                         serial data out (updated on TCK fall)
//   oRD_REQ/oRD_ADDR/iRD_DATA/iRD_VALID   read handshake
//   oWR_REQ/oWR_ADDR/oWR_DATA/iWR_ACK     write handshake
//   oBUSY                        a bus request is outstanding
//   oOVERRUN                     sticky: a JTAG event was dropped
module jtag_access_sequencer #(
  parameter int          NUMBER_OF_REGISTERS = 16,
  parameter int          REGISTER_SIZE       = 32,
  parameter logic [31:0] ID_CODE             = 32'h0000_0000,
  localparam int         ADDRESS_WIDTH       = $clog2(NUMBER_OF_REGISTERS + 1)
) (
  input  logic                       iMAIN_CLK,
  input  logic                       iRESET,
  input  logic [2*ADDRESS_WIDTH:0]   iIR,
  input  logic                       iTCK,
  input  logic                       iTDI,
  input  logic                       iSTATE_CDR,
  input  logic                       iSTATE_SDR,
  input  logic                       iSTATE_UDR,
  output logic                       oTDO,
  output logic                       oRD_REQ,
  output logic [ADDRESS_WIDTH-1:0]   oRD_ADDR,
  input  logic [REGISTER_SIZE-1:0]   iRD_DATA,
  input  logic                       iRD_VALID,
  output logic                       oWR_REQ,
  output logic [ADDRESS_WIDTH-1:0]   oWR_ADDR,
  output logic [REGISTER_SIZE-1:0]   oWR_DATA,
  input  logic                       iWR_ACK,
  output logic                       oBUSY,
  output logic                       oOVERRUN
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = $clog2(REGISTER_SIZE + 1);
  localparam logic [AW-1:0]            N_ADDR   = AW'(NUMBER_OF_REGISTERS);
  localparam logic [CW-1:0]            CNT_FULL = CW'(REGISTER_SIZE);
  localparam logic [REGISTER_SIZE-1:0] ID_VAL   = REGISTER_SIZE'(ID_CODE);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;

  state_t                   state_q, state_d;
  logic                     tck_q, udr_q;
  logic [REGISTER_SIZE-1:0] sr_q, sr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tdo_q, tdo_d;
  logic                     rd_req_q, rd_req_d;
  logic [AW-1:0]            rd_addr_q, rd_addr_d;
  logic                     wr_req_q, wr_req_d;
  logic [AW-1:0]            wr_addr_q, wr_addr_d;
  logic [REGISTER_SIZE-1:0] wr_data_q, wr_data_d;
  logic                     ovr_q, ovr_d;

  // IR decode
  logic          wr_en;
  logic [AW-1:0] ir_wr_addr, ir_rd_addr;
  assign wr_en      = iIR[2*AW];
  assign ir_wr_addr = iIR[2*AW-1:AW];
  assign ir_rd_addr = iIR[AW-1:0];

  // JTAG address 0 is the ID register; 1..N map to bus addresses 0..N-1.
  logic rd_mapped, wr_mapped, write_ok;
  assign rd_mapped = (ir_rd_addr != '0) && (ir_rd_addr <= N_ADDR);
  assign wr_mapped = (ir_wr_addr != '0) && (ir_wr_addr <= N_ADDR);
  assign write_ok  = wr_en && wr_mapped && (cnt_q == CNT_FULL);

  logic tck_rise, tck_fall, udr_rise;
  logic capture_ev, shift_ev, update_ev, any_ev;
  assign tck_rise   = iTCK & ~tck_q;
  assign tck_fall   = ~iTCK & tck_q;
  assign udr_rise   = iSTATE_UDR & ~udr_q;
  assign capture_ev = tck_rise & iSTATE_CDR;
  assign shift_ev   = tck_rise & iSTATE_SDR;
  assign update_ev  = udr_rise;
  assign any_ev     = capture_ev | shift_ev | update_ev;

  // State and datapath registers
  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) begin
      state_q   <= IDLE;
      tck_q     <= 1'b0;
      udr_q     <= 1'b0;
      sr_q      <= '0;
      cnt_q     <= '0;
      tdo_q     <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tck_q     <= iTCK;
      udr_q     <= iSTATE_UDR;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      tdo_q     <= tdo_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next state. Capture and shift take priority over a coincident update so
  // that a read and a write can never be launched in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture_ev) begin
          if (rd_mapped) state_d = READ_WAIT;
        end else if (!shift_ev && update_ev && write_ok) begin
          state_d = WRITE_WAIT;
        end
      end
      READ_WAIT:  if (iRD_VALID) state_d = IDLE;
      WRITE_WAIT: if (iWR_ACK)   state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Register updates
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    tdo_d     = tdo_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovr_d     = ovr_q;

    if (tck_fall) tdo_d = sr_q[0];

    case (state_q)
      IDLE: begin
        if (capture_ev) begin
          cnt_d = '0;
          if (ir_rd_addr == '0) begin
            sr_d = ID_VAL;
          end else if (rd_mapped) begin
            rd_addr_d = ir_rd_addr - AW'(1);
            rd_req_d  = 1'b1;
          end else begin
            sr_d = '0;
          end
        end else if (shift_ev) begin
          sr_d = {iTDI, sr_q[REGISTER_SIZE-1:1]};
          if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
        end else if (update_ev && write_ok) begin
          wr_addr_d = ir_wr_addr - AW'(1);
          wr_data_d = sr_q;
          wr_req_d  = 1'b1;
        end
      end
      READ_WAIT: begin
        // Events are dropped even in the completing cycle.
        if (any_ev) ovr_d = 1'b1;
        if (iRD_VALID) begin
          sr_d     = iRD_DATA;
          rd_req_d = 1'b0;
        end
      end
      WRITE_WAIT: begin
        if (any_ev) ovr_d = 1'b1;
        if (iWR_ACK) wr_req_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign oTDO     = tdo_q;
  assign oRD_REQ  = rd_req_q;
  assign oRD_ADDR = rd_addr_q;
  assign oWR_REQ  = wr_req_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_data_q;
  assign oBUSY    = (state_q == READ_WAIT) || (state_q == WRITE_WAIT);
  assign oOVERRUN = ovr_q;

endmodule
